// File: rtl/kmac_app_pkg.sv
// Shared types and default sizing for the KMAC application-port arbiter.
package kmac_app_pkg;

  localparam int unsigned DefNumApp        = 3;
  localparam int unsigned DefDW            = 64;
  localparam int unsigned DefDigestW       = 256;
  localparam int unsigned DefTimeoutCycles = 1024;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StMsg,
    StWait,
    StRsp
  } app_st_e;

  typedef struct packed {
    logic               valid;
    logic [DefDW-1:0]   data;
    logic [DefDW/8-1:0] strb;
    logic               last;
  } app_req_t;

  typedef struct packed {
    logic                  done;
    logic                  error;
    logic [DefDigestW-1:0] digest;
  } app_rsp_t;

endpackage

// File: rtl/kmac_app_rr_arb.sv
// Combinational round-robin pick: first set request at or after ptr, wrapping.
module kmac_app_rr_arb #(
  parameter int unsigned N = 3
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [$clog2(N)-1:0] gnt_idx,
  output logic                 gnt_valid
);

  localparam int unsigned IW = $clog2(N);

  always_comb begin
    int unsigned k;
    k         = 0;
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    for (int unsigned i = 0; i < N; i++) begin
      k = (32'(ptr) + i) % N;
      if (!gnt_valid && req[IW'(k)]) begin
        gnt_valid = 1'b1;
        gnt_idx   = IW'(k);
      end
    end
  end

endmodule

// File: rtl/kmac_app_arb.sv
// Shares the KMAC message/digest interface among NumApp requesters, one
// whole hash operation per round-robin grant.
module kmac_app_arb
  import kmac_app_pkg::*;
#(
  parameter int unsigned NumApp        = DefNumApp,
  parameter int unsigned DW            = DefDW,
  parameter int unsigned DigestW       = DefDigestW,
  parameter int unsigned TimeoutCycles = DefTimeoutCycles
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic [NumApp-1:0]           app_valid_i,
  input  logic [NumApp*DW-1:0]        app_data_i,
  input  logic [NumApp*DW/8-1:0]      app_strb_i,
  input  logic [NumApp-1:0]           app_last_i,
  output logic [NumApp-1:0]           app_ready_o,
  output logic [NumApp-1:0]           app_done_o,
  output logic                        app_error_o,
  output logic [DigestW-1:0]          app_digest_o,
  output logic                        kmac_start_o,
  output logic                        kmac_valid_o,
  output logic [DW-1:0]               kmac_data_o,
  output logic [DW/8-1:0]             kmac_strb_o,
  output logic                        kmac_last_o,
  input  logic                        kmac_ready_i,
  input  logic                        kmac_done_i,
  input  logic [DigestW-1:0]          kmac_digest_i,
  input  logic                        kmac_err_i,
  output logic                        busy_o,
  output logic [$clog2(NumApp)-1:0]   owner_o
);

  localparam int unsigned IW = $clog2(NumApp);
  localparam int unsigned CW = $clog2(TimeoutCycles);
  localparam int unsigned SW = DW / 8;

  app_st_e            state_q, state_d;
  logic [IW-1:0]      owner_q, rr_q, gnt_idx;
  logic               gnt_valid;
  logic [CW-1:0]      cnt_q;
  logic [DigestW-1:0] digest_q;
  logic               err_q;
  logic               rsp_load, rsp_err;
  logic               own_valid, own_last, beat_last, timeout;
  logic [DW-1:0]      data_arr [NumApp];
  logic [SW-1:0]      strb_arr [NumApp];

  for (genvar g = 0; g < NumApp; g++) begin : g_slice
    assign data_arr[g] = app_data_i[g*DW +: DW];
    assign strb_arr[g] = app_strb_i[g*SW +: SW];
  end

  kmac_app_rr_arb #(
    .N (NumApp)
  ) u_rr_arb (
    .req       (app_valid_i),
    .ptr       (rr_q),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid)
  );

  assign own_valid = app_valid_i[owner_q];
  assign own_last  = app_last_i[owner_q];
  assign beat_last = own_valid & kmac_ready_i & own_last;
  assign timeout   = (cnt_q == CW'(TimeoutCycles - 1));

  // Response capture: error beats done, done beats timeout.
  always_comb begin
    rsp_load = 1'b0;
    rsp_err  = 1'b0;
    if (state_q == StMsg && kmac_err_i) begin
      rsp_load = 1'b1;
      rsp_err  = 1'b1;
    end else if (state_q == StWait) begin
      if (kmac_err_i || kmac_done_i || timeout) begin
        rsp_load = 1'b1;
        rsp_err  = kmac_err_i | ~kmac_done_i;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= StIdle;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (gnt_valid) state_d = StStart;
      StStart: state_d = StMsg;
      StMsg:   if (rsp_load) state_d = StRsp;
               else if (beat_last) state_d = StWait;
      StWait:  if (rsp_load) state_d = StRsp;
      StRsp:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      owner_q  <= '0;
      rr_q     <= '0;
      cnt_q    <= '0;
      digest_q <= '0;
      err_q    <= 1'b0;
    end else begin
      if (state_q == StIdle && gnt_valid) owner_q <= gnt_idx;
      cnt_q <= (state_q == StWait) ? cnt_q + CW'(1) : '0;
      if (rsp_load) begin
        err_q    <= rsp_err;
        digest_q <= rsp_err ? '0 : kmac_digest_i;
      end
      if (state_q == StRsp) rr_q <= (owner_q == IW'(NumApp - 1)) ? '0 : owner_q + IW'(1);
    end
  end

  assign app_digest_o = digest_q;

  always_comb begin
    app_ready_o  = '0;
    app_done_o   = '0;
    app_error_o  = 1'b0;
    kmac_start_o = 1'b0;
    kmac_valid_o = 1'b0;
    kmac_data_o  = '0;
    kmac_strb_o  = '0;
    kmac_last_o  = 1'b0;
    busy_o       = (state_q != StIdle);
    owner_o      = (state_q == StIdle) ? '0 : owner_q;
    case (state_q)
      StStart: kmac_start_o = 1'b1;
      StMsg: begin
        kmac_valid_o         = own_valid;
        kmac_data_o          = data_arr[owner_q];
        kmac_strb_o          = strb_arr[owner_q];
        kmac_last_o          = own_last;
        app_ready_o[owner_q] = kmac_ready_i;
      end
      StRsp: begin
        app_done_o[owner_q] = 1'b1;
        app_error_o         = err_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_kmac_app_arb.sv
// Directed bench for kmac_app_arb with a per-cycle transaction-level reference model.
module tb_kmac_app_arb;

  localparam int NA  = 3;
  localparam int DW  = 64;
  localparam int DGW = 256;
  localparam int T   = 16;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NA-1:0]     app_valid_i = '0, app_last_i = '0, app_ready_o, app_done_o;
  logic [NA*DW-1:0]  app_data_i = '0;
  logic [NA*DW/8-1:0] app_strb_i = '0;
  logic              app_error_o;
  logic [DGW-1:0]    app_digest_o;
  logic              kmac_start_o, kmac_valid_o, kmac_last_o;
  logic [DW-1:0]     kmac_data_o;
  logic [DW/8-1:0]   kmac_strb_o;
  logic              kmac_ready_i = 1'b0, kmac_done_i = 1'b0, kmac_err_i = 1'b0;
  logic [DGW-1:0]    kmac_digest_i = '0;
  logic              busy_o;
  logic [1:0]        owner_o;

  kmac_app_arb #(
    .NumApp(NA), .DW(DW), .DigestW(DGW), .TimeoutCycles(T)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .app_valid_i(app_valid_i), .app_data_i(app_data_i), .app_strb_i(app_strb_i),
    .app_last_i(app_last_i), .app_ready_o(app_ready_o), .app_done_o(app_done_o),
    .app_error_o(app_error_o), .app_digest_o(app_digest_o),
    .kmac_start_o(kmac_start_o), .kmac_valid_o(kmac_valid_o), .kmac_data_o(kmac_data_o),
    .kmac_strb_o(kmac_strb_o), .kmac_last_o(kmac_last_o), .kmac_ready_i(kmac_ready_i),
    .kmac_done_i(kmac_done_i), .kmac_digest_i(kmac_digest_i), .kmac_err_i(kmac_err_i),
    .busy_o(busy_o), .owner_o(owner_o)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Requester and core stimulus state.
  int rem[NA], reload[NA], bc[NA];
  int done_dly = 0, core_cnt = 0;
  bit err_with_done = 0;

  // Observations logged at the negative edge.
  logic [NA-1:0] acc = '0;
  bit            kl = 0;
  int            ncyc = 0, last_cyc = 0, err_cyc = 0, start_cyc = 0, fwd1_cyc = 0;
  int            fwd = 0, done_n = 0, d_cyc = 0;
  logic [NA-1:0] d_val;
  logic          d_err;
  logic [DGW-1:0] d_dig;
  int            grants[$];
  logic [DW-1:0] fwd_data[$];

  // Reference model: one hash operation per grant, described by phase flags.
  bit m_busy = 0, m_rsp = 0, m_last = 0, m_rerr = 0;
  int m_own = 0, m_t = 0, m_wcnt = 0, m_rr = 0;
  logic [DGW-1:0] m_digest = '0;

  task automatic m_enter(input bit e);
    m_rsp    = 1;
    m_rerr   = e;
    m_digest = e ? '0 : kmac_digest_i;
  endtask

  always @(negedge clk) begin
    logic          e_start, e_valid, e_last, e_err, e_busy;
    logic [DW-1:0] e_data;
    logic [7:0]    e_strb;
    logic [NA-1:0] e_ready, e_done;
    logic [1:0]    e_owner;
    logic [DGW-1:0] e_dig;
    int idx;
    ncyc++;
    e_start = 0; e_valid = 0; e_last = 0; e_err = 0; e_busy = 0;
    e_data = '0; e_strb = '0; e_ready = '0; e_done = '0; e_owner = '0;
    e_dig = rst ? '0 : m_digest;
    if (!rst && m_busy) begin
      e_busy  = 1;
      e_owner = 2'(m_own);
      if (m_rsp) begin
        e_done[m_own] = 1'b1;
        e_err         = m_rerr;
      end else if (m_t == 1) begin
        e_start = 1;
      end else if (!m_last) begin
        e_valid        = app_valid_i[m_own];
        e_last         = app_last_i[m_own];
        e_data         = app_data_i[m_own*DW +: DW];
        e_strb         = app_strb_i[m_own*8 +: 8];
        e_ready[m_own] = kmac_ready_i;
      end
    end
    chk("start", kmac_start_o, e_start);
    chk("msg_valid_last", {kmac_valid_o, kmac_last_o}, {e_valid, e_last});
    chk("msg_data", kmac_data_o, e_data);
    chk("msg_strb", kmac_strb_o, e_strb);
    chk("ready", app_ready_o, e_ready);
    chk("done_err", {app_done_o, app_error_o}, {e_done, e_err});
    chk("digest", app_digest_o, e_dig);
    chk("busy_owner", {busy_o, owner_o}, {e_busy, e_owner});

    if (kmac_start_o) begin grants.push_back(int'(owner_o)); start_cyc = ncyc; end
    if (kmac_valid_o && kmac_ready_i) begin
      if (fwd == 0) fwd1_cyc = ncyc;
      fwd++;
      fwd_data.push_back(kmac_data_o);
    end
    kl = kmac_valid_o & kmac_ready_i & kmac_last_o;
    if (kl) last_cyc = ncyc;
    if (kmac_err_i) err_cyc = ncyc;
    if (|app_done_o) begin
      done_n++; d_val = app_done_o; d_err = app_error_o; d_dig = app_digest_o; d_cyc = ncyc;
    end
    acc = app_valid_i & app_ready_o;

    if (rst) begin
      m_busy = 0; m_rsp = 0; m_rr = 0; m_digest = '0;
    end else if (!m_busy) begin
      for (int k = 0; k < NA; k++) begin
        idx = (m_rr + k) % NA;
        if (!m_busy && app_valid_i[idx]) begin
          m_busy = 1; m_own = idx; m_t = 1; m_rsp = 0; m_last = 0;
        end
      end
    end else if (m_rsp) begin
      m_busy = 0; m_rsp = 0; m_rr = (m_own + 1) % NA;
    end else if (m_t == 1) begin
      m_t = 2;
    end else if (!m_last) begin
      if (kmac_err_i) m_enter(1);
      else if (app_valid_i[m_own] && kmac_ready_i && app_last_i[m_own]) begin
        m_last = 1; m_wcnt = 0;
      end
    end else begin
      if (kmac_err_i) m_enter(1);
      else if (kmac_done_i) m_enter(0);
      else if (m_wcnt == T - 1) m_enter(1);
      else m_wcnt++;
    end
  end

  task automatic drive_apps();
    for (int i = 0; i < NA; i++) begin
      app_valid_i[i]          = rem[i] > 0;
      app_last_i[i]           = rem[i] == 1;
      app_data_i[i*DW +: DW]  = {8'(i + 1), 24'h0, 32'(bc[i])};
      app_strb_i[i*8 +: 8]    = {4'(bc[i]), 4'(i + 1)};
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    for (int i = 0; i < NA; i++)
      if (acc[i]) begin
        bc[i]++;
        rem[i]--;
        if (rem[i] == 0) rem[i] = reload[i];
      end
    if (kl) core_cnt = done_dly;
    else if (core_cnt > 0) core_cnt--;
    kmac_done_i = (core_cnt == 1);
    kmac_err_i  = err_with_done && (core_cnt == 1);
    drive_apps();
  endtask

  task automatic clear_apps();
    for (int i = 0; i < NA; i++) begin rem[i] = 0; reload[i] = 0; bc[i] = 0; end
    drive_apps();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_apps();
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic wait_done(input string nm);
    int c0;
    bit ok;
    c0 = done_n;
    ok = 0;
    for (int i = 0; i < 200 && !ok; i++) begin
      tick();
      ok = done_n > c0;
    end
    if (!ok) chk(nm, ok, 1'b1);
  endtask

  task automatic quiet(input string nm);
    bit ok;
    ok = 0;
    for (int i = 0; i < 300 && !ok; i++) begin
      tick();
      ok = !busy_o && app_valid_i == '0;
    end
    if (!ok) chk(nm, ok, 1'b1);
  endtask

  function automatic int gat(input int i);
    return (grants.size() > i) ? grants[i] : 15;
  endfunction

  task automatic run_all(input int reqmask, input int ngrants, input string nm);
    bit ok;
    grants.delete();
    for (int i = 0; i < NA; i++) begin
      rem[i] = reqmask[i] ? 1 : 0;
      reload[i] = reqmask[i] ? 1 : 0;
    end
    drive_apps();
    ok = 0;
    for (int i = 0; i < 400 && !ok; i++) begin
      tick();
      ok = grants.size() >= ngrants;
    end
    if (!ok) chk(nm, ok, 1'b1);
    for (int i = 0; i < NA; i++) reload[i] = 0;
    quiet(nm);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int dn0;
    bit ok;
    clear_apps();
    tick(); tick();
    chk("rst_busy", {busy_o, app_done_o, kmac_start_o, kmac_valid_o}, '0);
    chk("rst_digest", app_digest_o, '0);
    rst = 1'b0;
    tick();

    // Single requester, 3 beats, digest after 5 cycles.
    grants.delete(); fwd_data.delete(); fwd = 0;
    kmac_ready_i = 1'b1; done_dly = 5; kmac_digest_i = {32{8'hA5}};
    rem[1] = 3;
    drive_apps();
    wait_done("sgl_timeout");
    chk("sgl_grant", gat(0), 1);
    chk("sgl_ngrant", grants.size(), 1);
    chk("sgl_beats", fwd, 3);
    chk("sgl_d0", fwd_data.size() > 0 ? fwd_data[0] : '0, 64'h0200_0000_0000_0000);
    chk("sgl_d2", fwd_data.size() > 2 ? fwd_data[2] : '0, 64'h0200_0000_0000_0002);
    chk("sgl_done", {d_val, d_err}, {3'b010, 1'b0});
    chk("sgl_digest", d_dig, {32{8'hA5}});
    chk("sgl_done_lat", d_cyc - last_cyc, 6);
    chk("sgl_beat_lat", fwd1_cyc - start_cyc, 1);
    quiet("sgl_quiet");

    // Fairness; pointer left at 2 by the previous grant to app 1.
    done_dly = 2; kmac_digest_i = {64{4'h7}};
    run_all(3'b111, 6, "rr_after_sgl");
    chk("rr_after_sgl", {gat(0), gat(1), gat(2), gat(3), gat(4), gat(5)}, {32'd2, 32'd0, 32'd1, 32'd2, 32'd0, 32'd1});
    do_reset();
    run_all(3'b111, 6, "rr_all");
    chk("rr_all", {gat(0), gat(1), gat(2), gat(3), gat(4), gat(5)}, {32'd0, 32'd1, 32'd2, 32'd0, 32'd1, 32'd2});
    do_reset();
    run_all(3'b101, 3, "rr_02");
    chk("rr_02", {gat(0), gat(1), gat(2)}, {32'd0, 32'd2, 32'd0});
    clear_apps();

    // Timeout with no digest.
    done_dly = 0; rem[2] = 1; drive_apps();
    wait_done("to_timeout");
    chk("to_done", {d_val, d_err}, {3'b100, 1'b1});
    chk("to_digest", d_dig, '0);
    chk("to_lat", d_cyc - (last_cyc + 1), 16);
    quiet("to_quiet");

    // Core error while the message is still streaming.
    kmac_ready_i = 1'b0; done_dly = 3; rem[1] = 3; drive_apps();
    ok = 0;
    for (int i = 0; i < 20 && !ok; i++) begin tick(); ok = kmac_valid_o; end
    if (!ok) chk("err_msg_reach", ok, 1'b1);
    kmac_err_i = 1'b1;
    wait_done("err_msg_timeout");
    rem[1] = 0; drive_apps();
    chk("err_msg_done", {d_val, d_err}, {3'b010, 1'b1});
    chk("err_msg_lat", d_cyc - err_cyc, 1);
    quiet("err_msg_quiet");

    // Done and error in the same WAIT cycle.
    kmac_ready_i = 1'b1; err_with_done = 1; rem[0] = 1; drive_apps();
    wait_done("err_dn_timeout");
    err_with_done = 0;
    chk("err_dn_done", {d_val, d_err}, {3'b001, 1'b1});
    chk("err_dn_digest", d_dig, '0);
    quiet("err_dn_quiet");

    // Backpressure on a 2-beat message.
    fwd = 0; fwd_data.delete(); bc[0] = 0; done_dly = 2; kmac_digest_i = {32{8'h3C}};
    rem[0] = 2; drive_apps();
    dn0 = done_n;
    for (int i = 0; i < 60 && done_n == dn0; i++) begin
      kmac_ready_i = (i % 2) == 0;
      tick();
    end
    if (done_n == dn0) chk("bp_timeout", 1'b0, 1'b1);
    kmac_ready_i = 1'b1;
    chk("bp_beats", fwd, 2);
    chk("bp_d0", fwd_data.size() > 0 ? fwd_data[0] : '0, 64'h0100_0000_0000_0000);
    chk("bp_d1", fwd_data.size() > 1 ? fwd_data[1] : '0, 64'h0100_0000_0000_0001);
    chk("bp_done", {d_val, d_err, d_dig}, {3'b001, 1'b0, {32{8'h3C}}});
    quiet("bp_quiet");

    // Reset asserted while waiting for the digest.
    fwd = 0; done_dly = 0; rem[2] = 1; drive_apps();
    for (int i = 0; i < 20 && fwd == 0; i++) tick();
    tick(); tick(); tick();
    dn0 = done_n;
    rst = 1'b1;
    #1;
    chk("rw_outputs", {busy_o, owner_o, app_done_o, app_error_o, app_ready_o, kmac_start_o, kmac_valid_o}, '0);
    chk("rw_digest", app_digest_o, '0);
    clear_apps();
    tick(); tick();
    rst = 1'b0;
    tick();
    chk("rw_no_done", done_n, dn0);
    run_all(3'b111, 1, "rw_rr");
    chk("rw_rr", gat(0), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/kmac_app_arb.md
Name: kmac_app_arb

Overview:
- Shares the single KMAC message/digest interface among NumApp hardware requesters (key manager, ROM check, etc.).
- Arbitration is round-robin at whole-message granularity. The block sequences one hash operation per grant: start, message stream, wait for digest, return digest.
- Sits between the application ports and the KMAC core, alongside the register-driven software path.

Parameters:
- NumApp, 3, number of requesters (2..8)
- DW, 64, message beat width in bits
- DigestW, 256, digest width returned to requesters
- TimeoutCycles, 1024, max cycles in WAIT before an error is returned (>=2)

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset; asynchronous, active-high
- app_valid_i  in  NumApp  per-requester message beat valid
- app_data_i  in  NumApp*DW  per-requester beat data; slice i belongs to requester i
- app_strb_i  in  NumApp*DW/8  per-requester byte strobes
- app_last_i  in  NumApp  last beat of message
- app_ready_o  out  NumApp  beat accepted when valid&ready
- app_done_o  out  NumApp  one-cycle pulse; digest/error valid for owner
- app_error_o  out  1  qualifies app_done_o: 1 = failed operation
- app_digest_o  out  DigestW  digest, shared bus, valid with app_done_o
- kmac_start_o  out  1  one-cycle start pulse to core
- kmac_valid_o  out  1  message beat valid to core
- kmac_data_o  out  DW  beat data
- kmac_strb_o  out  DW/8  beat strobes
- kmac_last_o  out  1  last beat
- kmac_ready_i  in  1  core accepts beat
- kmac_done_i  in  1  digest ready pulse
- kmac_digest_i  in  DigestW  digest from core
- kmac_err_i  in  1  core error pulse
- busy_o  out  1  high in any state except IDLE
- owner_o  out  $clog2(NumApp)  current grant index (0 in IDLE)

Behaviour:
- Reset:
  - All outputs are 0 and state is IDLE.
  - The rr pointer is 0.
  - The digest register and timeout counter clear.
- Request detection: requester i requests when app_valid_i[i]=1 in IDLE.
- Arbitration (IDLE):
  - Grant the first requesting index at or after the rr pointer, wrapping modulo NumApp.
  - Latch owner.
  - Go to START the next cycle.
  - No request -> stay IDLE.
- START: kmac_start_o=1 for exactly one cycle, then MSG. No beats are forwarded in START.
- MSG:
  - kmac_valid/data/strb/last mirror the owner's slice combinationally.
  - app_ready_o[owner]=kmac_ready_i; all other ready bits are 0.
  - Beat with last=1 accepted (valid&ready) -> WAIT.
  - The owner may drop valid mid-message; the grant holds regardless.
- WAIT:
  - Timeout counter counts from 0 each cycle.
  - kmac_done_i -> latch kmac_digest_i, go to RSP with error=0.
  - kmac_err_i -> RSP with error=1 and digest 0.
  - Counter reaches TimeoutCycles-1 with no done -> RSP with error=1 and digest 0.
- Error during MSG: kmac_err_i -> RSP with error=1. The remaining message is not drained; the owner's ready stays 0.
- Simultaneous done & err in WAIT: error wins.
- RSP:
  - app_done_o[owner]=1 for one cycle; app_error_o and app_digest_o are valid in the same cycle.
  - rr pointer <= (owner+1) mod NumApp.
  - Next state IDLE.
  - app_digest_o holds its value until the next RSP (not cleared).
- Minimum latency: request seen in IDLE -> start pulse 1 cycle later -> first beat forwarded 2 cycles after request.
- Done latency: app_done_o asserts 1 cycle after kmac_done_i.
- Fairness: a requester is never starved beyond NumApp-1 other grants.
- Reset mid-operation: immediate return to IDLE, outputs 0, no done pulse issued.
- Strobe width: DW must be a multiple of 8.

Decomposition:
- Package kmac_app_pkg:
  - app_st_e enum {StIdle, StStart, StMsg, StWait, StRsp}
  - app_req_t struct {valid, data, strb, last}
  - app_rsp_t struct {done, error, digest}
  - default NumApp / TimeoutCycles localparams
- Sub-module kmac_app_rr_arb: combinational round-robin pick from a request vector and pointer; outputs grant index and valid. Reusable elsewhere.

Test Plan:
- Single requester:
  - Stimulus: app 1 sends 3 beats (last on beat 3); core readies every cycle; kmac_done_i 5 cycles later with digest 0xA5..A5.
  - Response: start pulse once, 3 beats forwarded unchanged, app_done_o=3'b010 with error=0 and digest 0xA5..A5, rr pointer=2.
- Fairness:
  - Stimulus: apps 0, 1, 2 all request continuously with 1-beat messages.
  - Response: grant order 0,1,2,0,1,2.
  - Stimulus: only apps 0 and 2 request.
  - Response: order 0,2,0.
- Backpressure:
  - Stimulus: kmac_ready_i toggles 1,0,1,0 during a 2-beat message.
  - Response: each beat is forwarded exactly once; app_ready_o[owner] equals kmac_ready_i; other ready bits stay 0.
- Timeout:
  - Stimulus: TimeoutCycles=16, no kmac_done_i.
  - Response: app_done_o[owner] with error=1 exactly 16 cycles after entering WAIT; digest 0.
- Errors:
  - Stimulus: kmac_err_i mid-MSG.
  - Response: immediate RSP, error=1.
  - Stimulus: done and err in the same WAIT cycle.
  - Response: error=1.
- Reset:
  - Stimulus: rst_i asserted in WAIT.
  - Response: all outputs 0 the same cycle, no app_done_o pulse, rr pointer 0 afterwards.
